// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - operand-fetch / writeback sequencer for a single-port register file
//
// Purpose:
//   Takes an operand-fetch request (rs1, rs2) from decode and a writeback request from WB.
//   Both share one index/read/write port, so the controller sequences them onto it.
//   It captures the registered read data and valid flags, then hands both operands to
//   execute through a valid/ready handshake.
//   Writeback normally has priority. A read that has lost the port STARVE_LIMIT cycles
//   in a row is forced through.
//
// Optional build macro:
//   RFC_WB_BYPASS_EN - a performed writeback whose index matches a latched source index
//                      forwards its data into that operand while the request is in flight.
//
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_rs1/req_rs2  operand-fetch request from decode
//   wb_valid/wb_ready/wb_index/wb_data   writeback request from WB
//   rf_index/rf_read_en/rf_write_en/
//   rf_write_data                        register file port
//   rf_read_data/rf_flag                 registered read data and valid flag
//   op_valid/op_ready/op_a/op_b/
//   op_a_rdy/op_b_rdy                    operands to execute
module regfile_access_ctrl #(
    parameter int DATA_W       = 32,
    parameter int IDX_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_rs1,
    input  logic [IDX_W-1:0]  req_rs2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [IDX_W-1:0]  wb_index,
    input  logic [DATA_W-1:0] wb_data,
    output logic [IDX_W-1:0]  rf_index,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_flag,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_a_rdy,
    output logic              op_b_rdy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, CAPTURE_B, HOLD} state_t;

    state_t            state, nextState;
    logic [SW-1:0]     starve;
    logic [IDX_W-1:0]  rs1Lat, rs2Lat;
    logic              firstB;
    logic              readState, wbWin, readWin, wbPerform;
    logic              fwdA, fwdB;

    // Port arbitration. Writeback is gated by reset_n so that wb_ready stays low
    // while reset is held, even if WB keeps requesting.
    always_comb begin
        readState = (state == ISSUE_A) || (state == ISSUE_B);
        wbWin     = reset_n && wb_valid && (!readState || (starve < STARVE_MAX));
        readWin   = readState && !wbWin;
        // A winning writeback to x0 is acknowledged but never reaches the file.
        wbPerform = wbWin && (wb_index != '0);
    end

    always_comb begin
        fwdA = 1'b0;
        fwdB = 1'b0;
`ifdef RFC_WB_BYPASS_EN
        fwdA = wbPerform && (state != IDLE) && (wb_index == rs1Lat);
        fwdB = wbPerform && (state != IDLE) && (wb_index == rs2Lat);
`else
        fwdA = 1'b0;
        fwdB = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (req_valid) nextState = ISSUE_A;
            ISSUE_A:   if (readWin)   nextState = ISSUE_B;
            ISSUE_B:   if (readWin)   nextState = CAPTURE_B;
            CAPTURE_B:                nextState = HOLD;
            HOLD:      if (op_ready)  nextState = IDLE;
            default:                  nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready     = (state == IDLE);
        op_valid      = (state == HOLD);
        wb_ready      = wbWin;
        rf_write_en   = wbPerform;
        rf_read_en    = readWin;
        rf_write_data = wbPerform ? wb_data : '0;
        rf_index      = '0;
        if (wbPerform)    rf_index = wb_index;
        else if (readWin) rf_index = (state == ISSUE_A) ? rs1Lat : rs2Lat;
    end

    // Datapath: latched indices, starve counter, operand capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1Lat   <= '0;
            rs2Lat   <= '0;
            starve   <= '0;
            firstB   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_a_rdy <= 1'b0;
            op_b_rdy <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                rs1Lat <= req_rs1;
                rs2Lat <= req_rs2;
            end

            if (!readState)   starve <= '0;
            else if (readWin) starve <= '0;
            else              starve <= starve + 1'b1;

            // rs1 data appears only in the first ISSUE_B cycle; later cycles may be
            // spent waiting for the port and must not recapture.
            firstB <= (state == ISSUE_A) && readWin;

            // Forwarding takes priority over a same-cycle capture from the file.
            if (fwdA) begin
                op_a     <= wb_data;
                op_a_rdy <= 1'b1;
            end else if (state == ISSUE_B && firstB) begin
                op_a     <= (rs1Lat == '0) ? '0 : rf_read_data;
                op_a_rdy <= (rs1Lat == '0) ? 1'b1 : rf_flag;
            end

            if (fwdB) begin
                op_b     <= wb_data;
                op_b_rdy <= 1'b1;
            end else if (state == CAPTURE_B) begin
                op_b     <= (rs2Lat == '0) ? '0 : rf_read_data;
                op_b_rdy <= (rs2Lat == '0) ? 1'b1 : rf_flag;
            end
        end
    end

endmodule
